// File: rtl/gf_inverse_array.sv
// gf_inverse_array
//   Inverts a 2x2 matrix [[a,b],[c,d]] over GF(2^m), m = 2..MAX_DEG.
//   The field (degree m and irreducible polynomial) is supplied with each
//   matrix. The inverse is returned as d*inv, b*inv, c*inv, a*inv, where
//   inv = det^-1 and det = a*d + b*c. A singular matrix returns four zeros.
//
// Handshake: in_valid is high for exactly four consecutive beats (a, b, c, d),
//   with no backpressure. out_valid is high for exactly four consecutive
//   beats carrying the result. out_data is 0 whenever out_valid is 0.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous reset, active HIGH despite the name
//   in_valid  input beat qualifier
//   in_data   matrix entry, row-major
//   deg       field degree m, sampled on the first input beat
//   poly      irreducible polynomial (bit i = coeff of x^i), first beat only
//   out_data  inverse-matrix entry, row-major
//   out_valid output beat qualifier
module gf_inverse_array #(
  parameter int MAX_DEG = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [MAX_DEG-1:0] in_data,
  input  logic [2:0]         deg,
  input  logic [MAX_DEG:0]   poly,
  output logic [MAX_DEG-1:0] out_data,
  output logic               out_valid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_DET  = 3'd2,
    S_INV  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // r_state is the FSM state, left visible for debug probing.
  state_t             r_state;
  logic [1:0]         r_cnt;
  logic [2:0]         r_k;
  logic [2:0]         r_deg;
  logic [MAX_DEG:0]   r_poly;
  logic [MAX_DEG-1:0] r_a, r_b, r_c, r_d;
  logic [MAX_DEG-1:0] r_sq, r_acc;
  logic [MAX_DEG-1:0] r_out_data;
  logic               r_out_valid;

  logic [MAX_DEG-1:0] w_det, w_sq2, w_acc_next, w_sel, w_prod;

  // Carry-less multiply, reduced modulo p, by Horner shift-and-add from the
  // MSB. Each shift is reduced immediately, so the working value never holds
  // a bit at or above position m; the final mask is a safety net.
  function automatic logic [MAX_DEG-1:0] gf_mul(
    input logic [MAX_DEG-1:0] x,
    input logic [MAX_DEG-1:0] y,
    input logic [MAX_DEG:0]   p,
    input logic [2:0]         m
  );
    logic [MAX_DEG:0] t;
    logic [MAX_DEG:0] one;
    logic [MAX_DEG:0] mask;
    t    = '0;
    one  = {{MAX_DEG{1'b0}}, 1'b1};
    mask = (one << m) - one;
    for (int i = MAX_DEG - 1; i >= 0; i--) begin
      t = {t[MAX_DEG-1:0], 1'b0};
      if (t[m]) t = t ^ p;
      if (y[i]) t = t ^ {1'b0, x};
    end
    t = t & mask;
    return t[MAX_DEG-1:0];
  endfunction

  assign w_det      = gf_mul(r_a, r_d, r_poly, r_deg) ^ gf_mul(r_b, r_c, r_poly, r_deg);
  // Inverse as det^(2^m-2) = prod_{k=1..m-1} det^(2^k): square, then accumulate.
  assign w_sq2      = gf_mul(r_sq, r_sq, r_poly, r_deg);
  assign w_acc_next = gf_mul(r_acc, w_sq2, r_poly, r_deg);

  always_comb begin
    w_sel = r_a;
    case (r_cnt)
      2'd0:    w_sel = r_d;
      2'd1:    w_sel = r_b;
      2'd2:    w_sel = r_c;
      default: w_sel = r_a;
    endcase
  end

  // det == 0 yields r_acc == 0 after the first INV step, so a singular
  // matrix naturally produces four zero beats.
  assign w_prod = gf_mul(w_sel, r_acc, r_poly, r_deg);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_k         <= '0;
      r_deg       <= '0;
      r_poly      <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_sq        <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_data;
            r_deg   <= deg;
            r_poly  <= poly;
            r_cnt   <= 2'd1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          case (r_cnt)
            2'd1:    r_b <= in_data;
            2'd2:    r_c <= in_data;
            default: r_d <= in_data;
          endcase
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= S_DET;
        end
        S_DET: begin
          r_sq    <= w_det;
          r_acc   <= {{(MAX_DEG-1){1'b0}}, 1'b1};
          r_k     <= 3'd1;
          r_state <= S_INV;
        end
        S_INV: begin
          r_sq  <= w_sq2;
          r_acc <= w_acc_next;
          r_k   <= r_k + 3'd1;
          if (r_k == r_deg - 3'd1) begin
            r_cnt   <= 2'd0;
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_prod;
          r_cnt       <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_gf_inverse_array.sv
module tb_gf_inverse_array;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [4:0] in_data;
  logic [2:0] deg;
  logic [5:0] poly;
  logic [4:0] out_data;
  logic       out_valid;

  int n_vec;
  int n_err;

  gf_inverse_array #(.MAX_DEG(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .deg       (deg),
    .poly      (poly),
    .out_data  (out_data),
    .out_valid (out_valid)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one matrix as four beats on falling edges.
  task automatic send(input logic [2:0] m, input logic [5:0] p,
                      input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] c, input logic [4:0] d);
    logic [4:0] v [4];
    v[0] = a; v[1] = b; v[2] = c; v[3] = d;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = v[i];
      deg      = (i == 0) ? m : 3'd0;
      poly     = (i == 0) ? p : 6'd0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    deg      = '0;
    poly     = '0;
  endtask

  // Wait (bounded) for the result and check all four beats plus the idle after.
  task automatic expect_out(input string tag,
                            input logic [4:0] e0, input logic [4:0] e1,
                            input logic [4:0] e2, input logic [4:0] e3);
    logic [4:0] e [4];
    int cyc;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    // First sampling point is one cycle after the last input beat.
    cyc = 1;
    while (out_valid !== 1'b1 && cyc <= 20) begin
      check({tag, "_idle_data"}, int'(out_data), 0);
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency_ok"}, int'(out_valid === 1'b1), 1);
    if (out_valid === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("%s_valid%0d", tag, i), int'(out_valid), 1);
        check($sformatf("%s_data%0d", tag, i), int'(out_data), int'(e[i]));
        @(negedge clk);
      end
      check({tag, "_valid_fall"}, int'(out_valid), 0);
      check({tag, "_data_fall"}, int'(out_data), 0);
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    deg      = '0;
    poly     = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    check("reset_data", int'(out_data), 0);
    rst_n = 1'b0;
    @(negedge clk);

    // identity, GF(4)
    send(3'd2, 6'b000111, 5'd1, 5'd0, 5'd0, 5'd1);
    expect_out("ident_m2", 5'd1, 5'd0, 5'd0, 5'd1);
    @(negedge clk);

    // scalar 2*I, GF(4): det=3, inv=2
    send(3'd2, 6'b000111, 5'd2, 5'd0, 5'd0, 5'd2);
    expect_out("scalar_m2", 5'd3, 5'd0, 5'd0, 5'd3);
    @(negedge clk);

    // singular
    send(3'd2, 6'b000111, 5'd1, 5'd1, 5'd1, 5'd1);
    expect_out("singular_m2", 5'd0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);

    // GF(8), x^3+x+1: det=1
    send(3'd3, 6'b001011, 5'd2, 5'd1, 5'd1, 5'd0);
    expect_out("m3", 5'd0, 5'd1, 5'd1, 5'd2);
    @(negedge clk);

    // GF(32), x^5+x^2+1: det=2, inv=18
    send(3'd5, 6'b100101, 5'd2, 5'd0, 5'd0, 5'd1);
    expect_out("m5", 5'd18, 5'd0, 5'd0, 5'd1);
    @(negedge clk);

    // reset during the inverse computation aborts the burst
    send(3'd5, 6'b100101, 5'd3, 5'd1, 5'd2, 5'd7);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_valid", int'(out_valid), 0);
    check("abort_data", int'(out_data), 0);
    rst_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_silent", int'(out_valid), 0);
    end

    // next burst after the abort
    send(3'd3, 6'b001011, 5'd1, 5'd0, 5'd0, 5'd1);
    expect_out("post_reset", 5'd1, 5'd0, 5'd0, 5'd1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
